serial_adder_seq: RTL
=====================

# serial_adder_seq

Bit-serial adder sequencer. It takes two WIDTH-bit operands plus a carry-in and sums them LSB-first over WIDTH clock cycles. Each cycle it drives one operand bit pair and the running carry into the external NAND-only 3-input sum cell, then takes the sum bit back into a result shift register. It sits directly upstream of the sum cell and is the only block that drives the cell's a/b/c inputs and consumes its s output. The carry is generated and registered inside this block.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- cin  in  1  carry-in, sampled with start
- fa_a  out  1  operand-A bit to the sum cell
- fa_b  out  1  operand-B bit to the sum cell
- fa_c  out  1  carry bit to the sum cell
- fa_s  in  1  sum bit returned by the sum cell (combinational)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- sum  out  WIDTH  registered result, held between operations
- cout  out  1  registered carry-out, held between operations

## Operation
- States: IDLE, RUN, DONE. Bit counter cnt uses $clog2(WIDTH) bits.
- Internal registers:
  - A_sh, B_sh: operand shift registers.
  - R_sh: result shift register.
  - cy: running carry.
- **IDLE**
  - start=1 loads A_sh←a, B_sh←b, cy←cin, cnt←0, R_sh←0, then moves to RUN.
  - start=0 keeps the block in IDLE.
- **RUN**
  - fa_a=A_sh[0], fa_b=B_sh[0], fa_c=cy. These are combinational from registers only.
  - At each edge:
    - R_sh←{fa_s, R_sh[WIDTH-1:1]}
    - A_sh, B_sh shift right with 0 fill
    - cy←maj(A_sh[0], B_sh[0], cy)
    - cnt←cnt+1
  - At the edge where cnt==WIDTH-1:
    - sum←{fa_s, R_sh[WIDTH-1:1]} and cout←maj(...) load in the same edge.
    - State moves to DONE.
- **DONE**
  - done=1 for exactly one cycle.
  - The next edge returns to IDLE unconditionally.
- fa_a/fa_b/fa_c are 0 outside RUN.
- start is ignored in RUN and DONE. It is not queued, and in-flight operands are unaffected.
- sum/cout change only on the final RUN edge. They keep the last result through IDLE and through the whole of the next operation until that operation completes.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow is exactly cout.
- The sum cell is treated as ideal combinational logic with settle time within one clk period. The block adds no register between fa_s and R_sh.

## Timing
- Reset (async assert, release synchronous to clk):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_c=0.
  - All internal registers are 0.
- Latency, with start sampled at edge E0:
  - RUN is active from E0 to E_WIDTH.
  - done is high from E_WIDTH to E_WIDTH+1.
  - busy is high from E0 to E_WIDTH+1.
  - The earliest next accepted start is at E_WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Bit k (k=0..WIDTH-1) is presented to the sum cell in the cycle following edge E_k and captured at edge E_k+1.
- Reset mid-RUN or mid-DONE:
  - The block returns to IDLE immediately and asynchronously.
  - done is not emitted.
  - sum/cout clear to 0.
- Simultaneous start and rst: rst wins and start is dropped.
- start held high continuously: a new operation is accepted on each IDLE edge, i.e. back-to-back every WIDTH+2 cycles.

## Test plan
- **Reset values:** assert rst mid-cycle with no clock → busy=0, done=0, sum=0, cout=0, fa_*=0 immediately.
- **Carry ripple (WIDTH=8):** a=8'hFF, b=8'h01, cin=0, start at E0 → done high exactly between E8 and E9. Result sum=8'h00, cout=1. fa_c=1 during bits 1..7.
- **Carry-in propagation:** a=8'h5A, b=8'hA5, cin=1 → sum=8'h00, cout=1.
- **No carry:** a=8'h00, b=8'h00, cin=0 → sum=8'h00, cout=0. fa_a/fa_b/fa_c stay 0 throughout.
- **Start ignored while busy:** start at E0 with 8'h12+8'h34, then start re-pulsed at E3 with different operands → single done, sum=8'h46, cout=0. No second operation begins until the next IDLE start.
- **Reset mid-operation and random sweep:**
  - Reset asserted at E4 of an operation → no done, sum=0.
  - Then 1000 random {a,b,cin} with start held high → every result equals a+b+cin. Consecutive done pulses are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder sequencer.
// Feeds an external 3-input sum cell one operand bit pair per cycle, LSB first.
// The carry is kept locally, and the returned sum bits are collected into a
// result shift register. A full operation takes WIDTH+2 cycles, counting the
// IDLE cycle that accepts start.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_s,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] r_sh_reg;
   logic             cy_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;

   logic             last_bit;
   logic             carry_next;

   // The final bit is in flight when the counter reaches WIDTH-1.
   assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
   // Majority of the bits currently presented to the sum cell.
   assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) |
                       (a_sh_reg[0] & cy_reg) |
                       (b_sh_reg[0] & cy_reg);

   assign sum  = sum_reg;
   assign cout = cout_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and outputs. The sum cell is driven only while in RUN.
   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      done       = 1'b0;
      fa_a       = 1'b0;
      fa_b       = 1'b0;
      fa_c       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            fa_a = a_sh_reg[0];
            fa_b = b_sh_reg[0];
            fa_c = cy_reg;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: load the operands on accept, shift one bit per RUN cycle, and
   // publish the result only on the final RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_reg <= '0;
         b_sh_reg <= '0;
         r_sh_reg <= '0;
         cy_reg   <= 1'b0;
         cnt_reg  <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sh_reg <= a;
                  b_sh_reg <= b;
                  cy_reg   <= cin;
                  cnt_reg  <= '0;
                  r_sh_reg <= '0;
               end
            end
            RUN: begin
               r_sh_reg <= {fa_s, r_sh_reg[WIDTH-1:1]};
               a_sh_reg <= a_sh_reg >> 1;
               b_sh_reg <= b_sh_reg >> 1;
               cy_reg   <= carry_next;
               cnt_reg  <= cnt_reg + CW'(1);
               if (last_bit) begin
                  sum_reg  <= {fa_s, r_sh_reg[WIDTH-1:1]};
                  cout_reg <= carry_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
